// File: rtl/tx_pkg.sv
// Shared transmit-side types and constants: carrier LUT, phase stepping and FSM states.
package tx_pkg;

  localparam int unsigned NUM_CH       = 4;
  localparam int unsigned LUT_SIZE     = 5;
  localparam int unsigned CARRIER_STEP = 2;

  typedef logic signed [23:0] sample_t;
  typedef logic [1:0]         chan_t;
  typedef logic [2:0]         phase_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_t;

  localparam sample_t SINE_LUT [LUT_SIZE] = '{
    24'sd0, 24'sd7978040, 24'sd4930700, -24'sd4930700, -24'sd7978040
  };

  function automatic sample_t sine_lut(input phase_t idx);
    case (idx)
      3'd0:    return SINE_LUT[0];
      3'd1:    return SINE_LUT[1];
      3'd2:    return SINE_LUT[2];
      3'd3:    return SINE_LUT[3];
      3'd4:    return SINE_LUT[4];
      default: return '0;
    endcase
  endfunction

  // Out-of-range start phases fold to index 0.
  function automatic phase_t phase_fold(input phase_t p);
    return (32'(p) >= LUT_SIZE) ? '0 : p;
  endfunction

  function automatic phase_t phase_advance(input phase_t p);
    logic [3:0] s;
    s = {1'b0, p} + 4'(CARRIER_STEP);
    return (s >= 4'(LUT_SIZE)) ? phase_t'(s - 4'(LUT_SIZE)) : phase_t'(s);
  endfunction

endpackage

// File: rtl/tx_env_scale.sv
// Two-stage envelope datapath: S1 registers LUT value and env = amp*k >> RAMP_LOG2,
// S2 registers tdata = (LUT * env) >>> 16. Both stages advance only on en.
module tx_env_scale
  import tx_pkg::*;
#(
  parameter int unsigned RAMP_LOG2 = 2,
  parameter int unsigned K_W       = RAMP_LOG2 + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_valid,
  input  logic [23:0]    lut_val,
  input  logic [15:0]    amplitude,
  input  logic [K_W-1:0] k,
  input  logic [1:0]     in_user,
  input  logic           in_last,
  output logic [23:0]    out_data,
  output logic           out_valid,
  output logic [1:0]     out_user,
  output logic           out_last
);

  localparam int unsigned P_W = 16 + K_W;

  logic [P_W-1:0]     scaled;
  logic [15:0]        env;
  logic               s1_valid;
  sample_t            s1_lut;
  logic [15:0]        s1_env;
  chan_t              s1_user;
  logic               s1_last;
  logic signed [39:0] lut_ext;
  logic signed [39:0] env_ext;
  logic signed [39:0] prod;
  sample_t            mod_data;

  always_comb begin
    scaled   = (P_W'(amplitude) * P_W'(k)) >> RAMP_LOG2;
    env      = (|scaled[P_W-1:16]) ? '1 : scaled[15:0];
    lut_ext  = 40'(s1_lut);
    env_ext  = {24'd0, s1_env};
    prod     = lut_ext * env_ext;
    mod_data = sample_t'(prod >>> 16);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_lut    <= '0;
      s1_env    <= '0;
      s1_user   <= '0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_lut    <= lut_val;
      s1_env    <= env;
      s1_user   <= in_user;
      s1_last   <= in_last;
      out_valid <= s1_valid;
      out_data  <= mod_data;
      out_user  <= s1_user;
      out_last  <= s1_last;
    end
  end

endmodule

// File: rtl/tx_burst_gen.sv
// Sonar ping generator: interleaved 4-channel carrier at 2/5 fs with per-channel start
// phase and linear attack/release ramp, streamed out over AXI-Stream.
module tx_burst_gen
  import tx_pkg::*;
#(
  parameter int unsigned RAMP_LOG2 = 2,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             s_axis_aclk,
  input  logic             s_axis_aresetn,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [15:0]      amplitude,
  input  logic [11:0]      ch_phase,
  output logic             busy,
  output logic             done,
  output logic [23:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [1:0]       m_axis_tuser,
  output logic             m_axis_tlast
);

  localparam int unsigned      K_W   = RAMP_LOG2 + 1;
  localparam logic [LEN_W-1:0] R_LEN = LEN_W'(32'd1 << RAMP_LOG2);

  tx_state_t        state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] n_q;
  logic [15:0]      amp_q;
  phase_t           ph_q [NUM_CH];
  chan_t            c_q;
  logic             abort_q;
  logic             done_q;

  logic             en;
  logic             issue;
  logic             frame_end;
  logic             last_beat;
  logic             tlast_hs;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] kmin;
  logic [LEN_W-1:0] k_full;
  logic [K_W-1:0]   k;
  sample_t          lut_val;

  always_comb begin
    en        = m_axis_tready | ~m_axis_tvalid;
    issue     = (state_q == ST_RUN) && en;
    frame_end = (c_q == chan_t'(NUM_CH - 1));
    // A pending or same-cycle abort closes the burst on the current frame's last channel.
    last_beat = frame_end && ((n_q == len_q - LEN_W'(1)) || abort_q || abort);
    tlast_hs  = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    rem       = len_q - LEN_W'(1) - n_q;
    kmin      = (n_q < rem) ? n_q : rem;
    k_full    = (kmin > R_LEN) ? R_LEN : kmin;
    k         = K_W'(k_full);
    lut_val   = sine_lut(ph_q[c_q]);

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && (burst_len != '0)) state_d = ST_RUN;
      ST_RUN:   if (issue && last_beat)         state_d = ST_DRAIN;
      ST_DRAIN: if (tlast_hs)                   state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      n_q     <= '0;
      amp_q   <= '0;
      c_q     <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) ph_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= ((state_q == ST_IDLE) && start && (burst_len == '0)) ||
                 ((state_q == ST_DRAIN) && tlast_hs);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q   <= burst_len;
            amp_q   <= amplitude;
            n_q     <= '0;
            c_q     <= '0;
            abort_q <= abort;
            for (int unsigned i = 0; i < NUM_CH; i++)
              ph_q[i] <= phase_fold(ch_phase[3*i +: 3]);
          end
        end
        ST_RUN: begin
          if (abort) abort_q <= 1'b1;
          if (issue && !last_beat) begin
            if (frame_end) begin
              c_q <= '0;
              n_q <= n_q + LEN_W'(1);
              for (int unsigned i = 0; i < NUM_CH; i++)
                ph_q[i] <= phase_advance(ph_q[i]);
            end else begin
              c_q <= c_q + chan_t'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  tx_env_scale #(
    .RAMP_LOG2 (RAMP_LOG2),
    .K_W       (K_W)
  ) u_scale (
    .clk       (s_axis_aclk),
    .rst_n     (s_axis_aresetn),
    .en        (en),
    .in_valid  (issue),
    .lut_val   (lut_val),
    .amplitude (amp_q),
    .k         (k),
    .in_user   (c_q),
    .in_last   (last_beat),
    .out_data  (m_axis_tdata),
    .out_valid (m_axis_tvalid),
    .out_user  (m_axis_tuser),
    .out_last  (m_axis_tlast)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_tx_burst_gen.sv
// Directed self-checking bench for tx_burst_gen with an independent arithmetic reference.
module tb_tx_burst_gen;

  logic        s_axis_aclk;
  logic        s_axis_aresetn;
  logic        start;
  logic        abort;
  logic [15:0] burst_len;
  logic [15:0] amplitude;
  logic [11:0] ch_phase;
  logic        busy;
  logic        done;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [1:0]  m_axis_tuser;
  logic        m_axis_tlast;

  tx_burst_gen #(
    .RAMP_LOG2 (2),
    .LEN_W     (16)
  ) dut (
    .s_axis_aclk    (s_axis_aclk),
    .s_axis_aresetn (s_axis_aresetn),
    .start          (start),
    .abort          (abort),
    .burst_len      (burst_len),
    .amplitude      (amplitude),
    .ch_phase       (ch_phase),
    .busy           (busy),
    .done           (done),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast)
  );

  localparam longint LUT [5] = '{0, 7978040, 4930700, -4930700, -7978040};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rdy_pct = 100;
  int done_cnt = 0;
  int d0 = 0;
  int done_cyc = 0;
  int last_cyc = 0;
  int start_cyc = 0;
  int first_valid_cyc = -1;
  bit busy_seen = 0;
  bit prev_stall = 0;
  logic signed [63:0] hold_data;
  logic [1:0] hold_user;
  logic hold_last;
  logic signed [63:0] cap_data [$];
  int cap_user [$];
  int cap_last [$];

  initial begin
    s_axis_aclk = 0;
    forever #5 s_axis_aclk = ~s_axis_aclk;
  end

  always @(posedge s_axis_aclk) cyc <= cyc + 1;

  initial begin
    m_axis_tready = 1;
    forever begin
      @(posedge s_axis_aclk);
      #1;
      m_axis_tready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] model(int n, int c, int L, int amp, logic [11:0] ph);
    int p, idx, k, env;
    longint prod;
    p = ph[3*c +: 3];
    if (p > 4) p = 0;
    idx = (p + 2*n) % 5;
    k = n;
    if (k > 4) k = 4;
    if (L - 1 - n < k) k = L - 1 - n;
    env = (amp * k) >> 2;
    if (env > 65535) env = 65535;
    prod = LUT[idx] * longint'(env);
    return prod >>> 16;
  endfunction

  always @(negedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", $signed(m_axis_tdata), hold_data);
        check("hold_user", m_axis_tuser, hold_user);
        check("hold_last", m_axis_tlast, hold_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap_data.push_back($signed(m_axis_tdata));
        cap_user.push_back(int'(m_axis_tuser));
        cap_last.push_back(int'(m_axis_tlast));
        if (m_axis_tlast) last_cyc = cyc;
      end
      if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen = 1;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      hold_data  = $signed(m_axis_tdata);
      hold_user  = m_axis_tuser;
      hold_last  = m_axis_tlast;
    end
  end

  task automatic start_burst(input int L, input int amp, input logic [11:0] ph);
    @(posedge s_axis_aclk);
    #1;
    burst_len = 16'(L);
    amplitude = 16'(amp);
    ch_phase  = ph;
    cap_data.delete();
    cap_user.delete();
    cap_last.delete();
    busy_seen = 0;
    first_valid_cyc = -1;
    d0 = done_cnt;
    start_cyc = cyc;
    start = 1;
    @(posedge s_axis_aclk);
    #1;
    start = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    while (done_cnt == d0 && t < budget) begin
      @(negedge s_axis_aclk);
      #1;
      t++;
    end
    repeat (3) @(negedge s_axis_aclk);
    #1;
    check($sformatf("%s_done_pulses", tag), done_cnt - d0, 1);
  endtask

  task automatic verify_burst(input string tag, input int L, input int amp, input logic [11:0] ph, input int nbeats);
    check($sformatf("%s_beats", tag), cap_data.size(), nbeats);
    for (int i = 0; i < nbeats && i < cap_data.size(); i++) begin
      check($sformatf("%s_data[%0d]", tag, i), cap_data[i], model(i / 4, i % 4, L, amp, ph));
      check($sformatf("%s_user[%0d]", tag, i), cap_user[i], i % 4);
      check($sformatf("%s_last[%0d]", tag, i), cap_last[i], (i == nbeats - 1) ? 1 : 0);
    end
    check($sformatf("%s_tlast_to_done", tag), done_cyc - last_cyc, 1);
  endtask

  initial begin
    s_axis_aresetn = 0;
    start = 0;
    abort = 0;
    burst_len = 0;
    amplitude = 0;
    ch_phase = 0;
    repeat (3) @(posedge s_axis_aclk);
    #1;
    check("reset_tvalid", m_axis_tvalid, 0);
    check("reset_tdata", m_axis_tdata, 0);
    check("reset_tlast", m_axis_tlast, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge s_axis_aclk);
    s_axis_aresetn = 1;

    // Ramp
    rdy_pct = 100;
    start_burst(10, 65535, 12'h000);
    check("ramp_busy", busy, 1);
    wait_done("ramp", 500);
    check("ramp_latency", first_valid_cyc - start_cyc, 3);
    verify_burst("ramp", 10, 65535, 12'h000, 40);
    if (cap_data.size() >= 40) begin
      check("ramp_n0", cap_data[0], 0);
      check("ramp_n1", cap_data[4], 1232599);
      check("ramp_n4", cap_data[16], -4930625);
      for (int i = 36; i < 40; i++) check($sformatf("ramp_n9_c%0d", i - 36), cap_data[i], 0);
    end
    check("ramp_idle_busy", busy, 0);

    // Phase offsets
    start_burst(10, 65535, {3'd3, 3'd2, 3'd1, 3'd0});
    wait_done("phase", 500);
    verify_burst("phase", 10, 65535, {3'd3, 3'd2, 3'd1, 3'd0}, 40);
    if (cap_data.size() >= 40) begin
      check("phase_n5_c0", cap_data[20], 0);
      check("phase_n5_c1", cap_data[21], 7977918);
      check("phase_n5_c2", cap_data[22], 4930624);
      check("phase_n5_c3", cap_data[23], -4930625);
    end

    // Out-of-range start phases
    start_burst(10, 40000, {3'd7, 3'd6, 3'd5, 3'd4});
    wait_done("fold", 500);
    verify_burst("fold", 10, 40000, {3'd7, 3'd6, 3'd5, 3'd4}, 40);

    // Backpressure
    rdy_pct = 30;
    start_burst(10, 65535, 12'h000);
    wait_done("bp", 2000);
    verify_burst("bp", 10, 65535, 12'h000, 40);
    rdy_pct = 100;
    repeat (2) @(posedge s_axis_aclk);

    // Abort during frame 7, channel 1
    start_burst(100, 65535, 12'h000);
    repeat (29) @(posedge s_axis_aclk);
    #1;
    abort = 1;
    @(posedge s_axis_aclk);
    #1;
    abort = 0;
    wait_done("abort", 1000);
    verify_burst("abort", 100, 65535, 12'h000, 32);

    // Start and abort together
    @(posedge s_axis_aclk);
    #1;
    abort = 1;
    start_burst(50, 30000, 12'h000);
    abort = 0;
    wait_done("start_abort", 500);
    verify_burst("start_abort", 50, 30000, 12'h000, 4);

    // Zero length
    start_burst(0, 65535, 12'h000);
    wait_done("len0", 50);
    check("len0_beats", cap_data.size(), 0);
    check("len0_busy_seen", busy_seen, 0);
    check("len0_no_valid", first_valid_cyc, -1);

    // Start while busy
    start_burst(10, 65535, 12'h000);
    repeat (5) @(posedge s_axis_aclk);
    #1;
    burst_len = 3;
    amplitude = 1000;
    start = 1;
    @(posedge s_axis_aclk);
    #1;
    start = 0;
    wait_done("busy_start", 500);
    verify_burst("busy_start", 10, 65535, 12'h000, 40);

    // Single sample
    start_burst(1, 65535, {3'd3, 3'd2, 3'd1, 3'd0});
    wait_done("len1", 100);
    verify_burst("len1", 1, 65535, {3'd3, 3'd2, 3'd1, 3'd0}, 4);

    // Reset mid-burst, then replay
    begin
      int t = 0;
      start_burst(20, 65535, 12'h000);
      while (cap_data.size() < 13 && t < 200) begin
        @(posedge s_axis_aclk);
        #2;
        t++;
      end
      check("rst_reached_beat13", cap_data.size(), 13);
      s_axis_aresetn = 0;
      #1;
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_tuser", m_axis_tuser, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      repeat (4) @(negedge s_axis_aclk);
      check("rst_no_done", done_cnt - d0, 0);
      s_axis_aresetn = 1;
      start_burst(20, 65535, 12'h000);
      wait_done("replay", 500);
      verify_burst("replay", 20, 65535, 12'h000, 80);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_burst_gen.md
Name: tx_burst_gen

Overview:
- Transmit-side counterpart of the receive demodulator: generates the sonar ping as an interleaved 4-channel AXI-Stream of carrier samples.
- Carrier runs at 2/5 fs; each channel advances its 5-entry sine LUT index by +2 mod 5 per sample.
- Each channel takes a programmable start-phase offset for coarse beam steering. A linear attack/release ramp limits spectral splatter.
- Sits between the ping control registers and the DAC/transducer driver stream.

Parameters:
- RAMP_LOG2, 2, ramp length R = 2^RAMP_LOG2 samples per edge (valid range 0..8).
- LEN_W, 16, width of burst_len.

Ports:
- s_axis_aclk  in  1  clock.
- s_axis_aresetn  in  1  reset: asynchronous assert, active-low.
- start  in  1  one-cycle pulse; launches a burst.
- abort  in  1  level/pulse; ends the burst early at the next frame boundary.
- burst_len  in  LEN_W  samples per channel; latched on accepted start.
- amplitude  in  16  unsigned peak gain (65535 ≈ 1.0); latched on accepted start.
- ch_phase  in  4x3  per-channel start LUT index 0..4; values 5..7 are treated as 0. Latched on accepted start.
- busy  out  1  high from accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse at burst end.
- m_axis_tdata  out  24  signed modulated sample.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tuser  out  2  channel index 0..3.
- m_axis_tlast  out  1  high on the final beat of the burst.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; pipeline valids cleared. Mid-burst reset aborts the burst silently (no done pulse).
- LUT (signed 24-bit): {0, 7978040, 4930700, -4930700, -7978040}.
- Beat order: each sample index n emits a frame of 4 beats, tuser = 0,1,2,3. n runs 0..L-1, L = latched burst_len.
- Phase: idx(c,n) = (ch_phase[c] + 2n) mod 5. Keep a per-channel phase register; do not use a multiplier.
- Envelope:
  - k(n) = min(n, R, L-1-n).
  - env = (amplitude * k) >> RAMP_LOG2, 16 bits, saturating at 65535.
  - tdata = (LUT[idx] * env) >>> 16, arithmetic (floor) shift, 40-bit intermediate.
- Pipeline:
  - Three stages: S0 counter/FSM, S1 registered LUT value + env + tuser/tlast, S2 output register.
  - Whole pipeline advances when en = m_axis_tready | ~m_axis_tvalid.
  - No new data enters while a stage is stalled.
  - tdata/tuser/tlast are stable while tvalid && !tready.
- Latency: start accepted at cycle t → first tvalid at t+3 with tready held high. Throughput is 1 beat/cycle.
- FSM:
  - IDLE: start && L>0 → RUN. start && L==0 → done pulse next cycle, no beats, busy stays low.
  - RUN: issue beats into S0. After issuing (n=L-1, c=3), or at a frame boundary with abort seen, go to DRAIN. The issued last beat carries tlast.
  - abort is sampled high any time in RUN and takes effect after the current frame's c=3 beat. That beat is marked tlast.
  - DRAIN: wait for the tlast beat handshake; the next cycle pulses done and returns to IDLE.
- start while busy is ignored.
- start and abort in the same cycle: start is accepted, and the burst ends after frame n=0.
- burst_len=1: k=0, so one frame of four zero samples with tlast on c=3.

Decomposition:
- Shared package tx_pkg: SINE_LUT constant (shared with the demodulator), CARRIER_STEP=2, LUT_SIZE=5, sample_t (signed [23:0]), chan_t ([1:0]), NUM_CH=4.
- One sub-module, tx_env_scale: pipelined amplitude*k>>RAMP_LOG2 and LUT*env>>>16 datapath with enable input. The FSM/counters stay in the top module.

Test Plan:
- Ramp check: RAMP_LOG2=2, amplitude=65535, ch_phase=0, L=10, tready=1.
  - n=0 ch0 → 0.
  - n=1 ch0 (idx2, env 16383) → 1232599.
  - n=4 ch0 (idx3, env 65535) → -4930625.
  - n=9 all channels → 0.
  - 40 beats total, tlast only on beat 40, done 1 cycle after it.
- Phase offsets: ch_phase={0,1,2,3}, R at full envelope. Frame n=5 indices are {0,1,2,3} → tdata ch0 0, ch1 7977918, ch2 4930624, ch3 -4930625.
- Backpressure: random tready at 30%. Beat sequence is identical to the tready=1 run, held values are stable while stalled, and no beats are dropped or duplicated.
- Abort: L=100, abort pulses during frame n=7 at c=1. Beats stop after frame 7 c=3, which has tlast; 32 beats total; done pulses.
- Edge cases:
  - L=0 → done pulse, no tvalid.
  - start while busy → ignored, beat count unchanged.
  - L=1 → 4 zero beats, tlast on tuser=3.
- Reset mid-burst: assert aresetn low at beat 13. Outputs go to 0 immediately (asynchronously), there is no done pulse, and a fresh start afterwards replays the full correct burst.
